// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared types and constants for the fetch controller.
//   state_t   - fetch FSM states IDLE/RUN/WAIT/HALT
//   PC_W      - program counter width (16)
//   RESET_VEC - pc value on reset (16'h0000)
//   PC_INC    - sequential increment (16'h0002)
package pc_fetch_ctrl_pkg;
    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_VEC = 16'h0000;
    localparam logic [PC_W-1:0] PC_INC = 16'h0002;
    typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;
endpackage

// File: rtl/pc_fetch_ctrl_adder.sv
// pc_plus2_adder: sequential-successor adder, wraps modulo 2^16.
//   pc_i       - current pc
//   pc_plus2_o - pc_i + 2, carry out discarded
module pc_plus2_adder
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_plus2_o
);
    assign pc_plus2_o = pc_i + PC_INC;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch PC controller (IDLE/RUN/WAIT/HALT FSM).
//   in : clk, rst (async active-high), stall, redirect, redirect_pc[15:0], halt, imem_ready
//   out: pc[15:0], pc_plus2[15:0], fetch_valid, halted, misalign_err
//   Optional macro PC_MISALIGN_CHK_EN: an odd redirect target halts fetch and
//   raises a sticky misalign_err; otherwise the target's bit 0 is cleared.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    input  logic            imem_ready,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic            fetch_valid,
    output logic            halted,
    output logic            misalign_err
);
    state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    pc_plus2_adder u_adder (.pc_i(pc_q), .pc_plus2_o(pc_plus2));

`ifdef PC_MISALIGN_CHK_EN
    logic mis_q, mis_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    assign misalign_err = mis_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Priority in RUN/WAIT: halt > redirect > stall > imem_ready.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_MISALIGN_CHK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: state_d = RUN;
            RUN, WAIT: begin
                if (halt) begin
                    state_d = HALT;
                end else if (redirect) begin
                    state_d = RUN;
                    pc_d    = {redirect_pc[PC_W-1:1], 1'b0};
`ifdef PC_MISALIGN_CHK_EN
                    if (redirect_pc[0]) begin
                        state_d = HALT;
                        pc_d    = pc_q;
                        mis_d   = 1'b1;
                    end
`endif
                end else if (!stall) begin
                    state_d = imem_ready ? RUN : WAIT;
                    pc_d    = imem_ready ? pc_plus2 : pc_q;
                end
            end
            default: ;
        endcase
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN) || (state_q == WAIT);
    assign halted      = (state_q == HALT);
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        imem_ready = 1'b0;
    logic [15:0] pc, pc_plus2;
    logic        fetch_valid, halted, misalign_err;
    int          vecs = 0;
    int          fails = 0;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .imem_ready(imem_ready),
        .pc(pc), .pc_plus2(pc_plus2), .fetch_valid(fetch_valid),
        .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [15:0] exp_pc, input logic exp_fv,
                             input logic exp_h, input logic exp_m);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_fv"}, {15'd0, fetch_valid}, {15'd0, exp_fv});
        chk({tag, "_halted"}, {15'd0, halted}, {15'd0, exp_h});
        chk({tag, "_mis"}, {15'd0, misalign_err}, {15'd0, exp_m});
    endtask

    task automatic jump(input logic [15:0] tgt);
        redirect = 1'b1;
        redirect_pc = tgt;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        #1;
        chk_flags("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        imem_ready = 1'b1;
        chk_flags("idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(); chk_flags("run0", 16'h0000, 1'b1, 1'b0, 1'b0);
        step(); chk("seq2", pc, 16'h0002);
        step(); chk("seq4", pc, 16'h0004);
        step(); chk("seq6", pc, 16'h0006);
        chk("plus2_6", pc_plus2, 16'h0008);

        jump(16'hFFFE);
        chk("pc_fffe", pc, 16'hFFFE);
        chk("plus2_wrap", pc_plus2, 16'h0000);
        step(); chk("wrap_pc", pc, 16'h0000);

        jump(16'h0010);
        chk("pc_10", pc, 16'h0010);
        stall = 1'b1; imem_ready = 1'b0;
        jump(16'h0100);
        chk_flags("redir_over_stall", 16'h0100, 1'b1, 1'b0, 1'b0);
        chk("redir_state", {14'd0, dut.state_q}, {14'd0, RUN});
        imem_ready = 1'b1;
        step(); chk("stall_hold", pc, 16'h0100);
        step(); chk("stall_hold2", pc, 16'h0100);
        stall = 1'b0;

        jump(16'h0020);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_flags("wait", 16'h0020, 1'b1, 1'b0, 1'b0);
        end
        imem_ready = 1'b1;
        step(); chk("wait_exit", pc, 16'h0022);

        jump(16'h0040);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
        step();
        chk_flags("halt", 16'h0040, 1'b0, 1'b1, 1'b0);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall = i[0];
            step();
            chk_flags("halt_hold", 16'h0040, 1'b0, 1'b1, 1'b0);
        end
        redirect = 1'b0; stall = 1'b0;
        rst = 1'b1;
        #1;
        chk_flags("async_rst_halt", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step(); step();
        chk("restart", pc, 16'h0002);

        imem_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk_flags("async_rst_wait", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        imem_ready = 1'b1;

        jump(16'h0101);
`ifdef PC_MISALIGN_CHK_EN
        chk_flags("misalign", 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        chk_flags("misalign_sticky", 16'h0000, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk_flags("misalign_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
`else
        chk_flags("odd_target", 16'h0100, 1'b1, 1'b0, 1'b0);
        step();
        chk_flags("odd_next", 16'h0102, 1'b1, 1'b0, 1'b0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL provide ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide ports: stall  in  1  pipeline hazard, hold PC.
REQ-004 SHALL provide ports: redirect  in  1  branch/jump taken, load redirect_pc.
REQ-005 SHALL provide ports: redirect_pc  in  16  branch/jump target.
REQ-006 SHALL provide ports: halt  in  1  HALT instruction decoded.
REQ-007 SHALL provide ports: imem_ready  in  1  instruction memory accepts fetch this cycle.
REQ-008 SHALL provide ports: pc  out  16  current fetch address.
REQ-009 SHALL provide ports: pc_plus2  out  16  pc + 2, sequential successor.
REQ-010 SHALL provide ports: fetch_valid  out  1  pc is a live fetch request.
REQ-011 SHALL provide ports: halted  out  1  fetch stopped permanently until reset.
REQ-012 SHALL provide ports: misalign_err  out  1  odd redirect target detected.

Function
REQ-013 SHALL implement four states: IDLE, RUN, WAIT, HALT.
REQ-014 SHALL move IDLE -> RUN unconditionally one cycle after reset release; pc holds 0x0000, fetch_valid 0 in IDLE.
REQ-015 SHALL drive fetch_valid=1 in RUN and WAIT, 0 in IDLE and HALT.
REQ-016 SHALL apply event priority per cycle in RUN/WAIT: halt > redirect > stall > imem_ready.
REQ-017 SHALL, on halt, enter HALT next cycle with pc frozen at its current value and halted=1.
REQ-018 SHALL, on redirect (no halt), load pc <= redirect_pc next cycle and enter RUN, regardless of stall or imem_ready.
REQ-019 SHALL, on stall (no halt/redirect), hold pc and state.
REQ-020 SHALL, in RUN with imem_ready=1 and no higher event, advance pc <= pc_plus2.
REQ-021 SHALL, in RUN with imem_ready=0 and no higher event, hold pc and enter WAIT; WAIT returns to RUN and advances pc on the first cycle imem_ready=1.
REQ-022 SHALL compute pc_plus2 combinationally as pc + 16'h0002 modulo 2^16 (0xFFFE -> 0x0000, no carry out).
REQ-023 SHALL ignore stall, redirect, imem_ready and halt in HALT; only rst exits HALT.
REQ-024 SHALL, without the check feature, load redirect_pc with bit 0 forced to 0.

Reset
REQ-025 SHALL, while rst=1 and asynchronously on assertion: pc=0x0000, state IDLE, fetch_valid=0, halted=0, misalign_err=0.
REQ-026 SHALL abandon any in-flight WAIT, redirect or halt on reset mid-operation; no state survives.

Configuration
REQ-027 SHALL use macro PC_MISALIGN_CHK_EN: when defined, a redirect with redirect_pc[0]=1 enters HALT next cycle, pc not loaded, misalign_err=1 sticky until reset.
REQ-028 SHALL, without PC_MISALIGN_CHK_EN, tie misalign_err to 0 and follow REQ-024.

Structure
REQ-029 SHALL place in a shared package: state enum (IDLE/RUN/WAIT/HALT), PC width constant 16, reset vector 16'h0000, increment constant 16'h0002.
REQ-030 SHALL contain exactly one sub-module, pc_plus2_adder, 16-bit adder producing pc_plus2.

Verification
REQ-031 SHALL verify: reset release, imem_ready=1 for 4 cycles -> pc 0x0000 (IDLE), 0x0000, 0x0002, 0x0004, 0x0006.
REQ-032 SHALL verify: pc=0xFFFE, imem_ready=1 -> next pc=0x0000, pc_plus2 at 0xFFFE reads 0x0000.
REQ-033 SHALL verify: pc=0x0010, stall=1 and redirect=1 with redirect_pc=0x0100, imem_ready=0 -> next pc=0x0100, state RUN.
REQ-034 SHALL verify: imem_ready=0 for 3 cycles at pc=0x0020 -> pc held 0x0020, fetch_valid=1; ready returns -> pc=0x0022.
REQ-035 SHALL verify: halt with redirect same cycle at pc=0x0040 -> halted=1, pc=0x0040 forever, fetch_valid=0; rst -> pc=0x0000.
REQ-036 SHALL verify: redirect_pc=0x0101 -> with PC_MISALIGN_CHK_EN HALT, misalign_err=1; without it pc=0x0100, misalign_err=0.
